uni_shft_ctrl: RTL and testbench
================================

// Module: uni_shft_ctrl
// PURPOSE
//  Sequencer for the universal shift register (sel: 0 hold, 1 shift right, 2 shift left, 3 parallel load).
//  Accepts one TX (parallel->serial) or RX (serial->parallel) command per valid/ready handshake.
//  Drives sel/par_in/ser_inl/ser_inr and reads par_out/ser_outr/ser_outl back.
//  Sits between a command source and one shift-register instance as its only driver.
// PARAMETERS
//  WIDTH   4   shift register width in bits (>=2); counter width $clog2(WIDTH+1)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      controller idle, command accepted when valid&ready
//  cmd_mode     in   1      0 = TX, 1 = RX
//  cmd_dir      in   1      0 = shift right (sel=1), 1 = shift left (sel=2)
//  cmd_data     in   WIDTH  TX word to load (ignored for RX)
//  abort        in   1      synchronous cancel of the running command
//  sr_sel       out  2      to register sel
//  sr_par_in    out  WIDTH  to register par_in
//  sr_ser_inr   out  1      to register right-shift serial input
//  sr_ser_inl   out  1      to register left-shift serial input
//  sr_par_out   in   WIDTH  from register
//  sr_ser_outr  in   1      from register, bit leaving on a right shift
//  sr_ser_outl  in   1      from register, bit leaving on a left shift
//  ser_rx_in    in   1      external serial bit for RX
//  rx_bit_ready out  1      ser_rx_in consumed at this rising edge
//  ser_tx_out   out  1      serial TX bit
//  tx_bit_valid out  1      ser_tx_out valid this cycle
//  rx_data      out  WIDTH  captured RX word
//  rx_valid     out  1      one-cycle pulse, rx_data updated
//  busy         out  1      command in progress (state != IDLE)
//  done         out  1      one-cycle pulse in DONE state (not on abort)
// BEHAVIOUR
//  Reset (async): state IDLE, counter 0, mode/dir/data regs 0, rx_data 0, rx_valid 0.
//   All sr_* outputs 0 (sel=0 = hold). The controller never resets the register's contents.
//  FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE. sr_* outputs are Moore-decoded from state and latched cmd regs.
//   - IDLE: cmd_ready=1, sel=0. On valid&ready, latch mode/dir/data -> LOAD.
//   - LOAD: sel=3. sr_par_in = latched data for TX, 0 for RX (clears register). Counter=0 -> SHIFT.
//   - SHIFT: sel = dir ? 2 : 1. Counter increments each cycle; on the cycle counter==WIDTH-1 -> DONE.
//     Exactly WIDTH shift edges.
//   - DONE: sel=0, done=1. At its edge, if RX: rx_data<=sr_par_out and rx_valid<=1 for next cycle. -> IDLE.
//  TX in SHIFT:
//   - ser_tx_out = dir ? sr_ser_outl : sr_ser_outr (combinational); tx_bit_valid=1.
//   - Both ser_in = 0 (zero fill).
//  RX in SHIFT:
//   - Active-direction ser_in = ser_rx_in (ser_inl if dir=1, else ser_inr); other ser_in = 0.
//   - rx_bit_ready=1.
//  Outside SHIFT: tx_bit_valid=0, rx_bit_ready=0, ser_tx_out=0, both ser_in=0.
//  Latency: accept edge -> LOAD 1 cycle, SHIFT WIDTH cycles, DONE 1 cycle.
//   cmd_ready returns WIDTH+2 cycles after accept. Back-to-back commands allowed from the first IDLE cycle.
//  cmd_valid while busy: ignored (ready=0). Source must hold the command until accepted.
//  abort (any non-IDLE state): next edge -> IDLE, sel=0, no done, no rx_valid, rx_data unchanged. Ignored in IDLE.
//   abort takes priority over every state transition.
//  rst asserted mid-command: immediate IDLE, outputs to reset values. No done, no rx_valid.
//  busy = state != IDLE. done and rx_valid are never asserted for more than one cycle.
// TESTING (WIDTH=4; bench model: right shift emits par_out[0], left emits par_out[3])
//  1 TX right, data=4'b1011 -> sel seq 3,1,1,1,1,0; ser_tx_out 1,1,0,1 with tx_bit_valid; done 1 cycle; ready after 6 cycles.
//  2 TX left, data=4'b1011 -> ser_tx_out 1,0,1,1; final par_out 4'b0000.
//  3 RX right, ser_rx_in 1,1,0,1 -> rx_valid 1 cycle after DONE with rx_data matching model (par_out after 4 shifts).
//  4 RX left, ser_rx_in 0,1,1,0 -> rx_data=4'b0110, rx_valid single pulse.
//  5 abort in 2nd SHIFT cycle of TX -> IDLE next cycle, sel=0, no done; next command accepted normally.
//  6 rst pulse mid-RX (#2 asynchronous) -> all outputs 0 immediately; cmd_valid held high during busy -> exactly one accept.

Source files
------------

// File: rtl/uni_shft_ctrl_if.sv
// Command handshake bundle between a command source and the shift-register sequencer.
interface uni_shft_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, cmd_mode, cmd_dir, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_mode, cmd_dir, cmd_data, output cmd_ready);
endinterface

// File: rtl/uni_shft_ctrl.sv
// Sequencer for a universal shift register: runs one TX (parallel->serial) or
// RX (serial->parallel) command per handshake as LOAD, WIDTH shifts, DONE.
module uni_shft_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    uni_shft_ctrl_if.slave   cmd,
    input  logic             abort,
    output logic [1:0]       sr_sel,
    output logic [WIDTH-1:0] sr_par_in,
    output logic             sr_ser_inr,
    output logic             sr_ser_inl,
    input  logic [WIDTH-1:0] sr_par_out,
    input  logic             sr_ser_outr,
    input  logic             sr_ser_outl,
    input  logic             ser_rx_in,
    output logic             rx_bit_ready,
    output logic             ser_tx_out,
    output logic             tx_bit_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;
    localparam logic [1:0] SEL_LOAD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;

    // State and command registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            dir_q      <= 1'b0;
            data_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            data_q     <= data_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Next state; abort overrides every transition outside IDLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        data_d     = data_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    mode_d  = cmd.cmd_mode;
                    dir_d   = cmd.cmd_dir;
                    data_d  = cmd.cmd_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (mode_q) begin
                    rx_data_d  = sr_par_out;
                    rx_valid_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            rx_data_d  = rx_data_q;
            rx_valid_d = 1'b0;
        end
    end

    // Moore decode of register controls; TX bit passes straight through from the register
    always_comb begin
        sr_sel       = SEL_HOLD;
        sr_par_in    = '0;
        sr_ser_inr   = 1'b0;
        sr_ser_inl   = 1'b0;
        ser_tx_out   = 1'b0;
        tx_bit_valid = 1'b0;
        rx_bit_ready = 1'b0;

        case (state_q)
            ST_LOAD: begin
                sr_sel    = SEL_LOAD;
                sr_par_in = mode_q ? '0 : data_q;
            end
            ST_SHIFT: begin
                sr_sel = dir_q ? SEL_LEFT : SEL_RIGHT;
                if (mode_q) begin
                    rx_bit_ready = 1'b1;
                    if (dir_q) begin
                        sr_ser_inl = ser_rx_in;
                    end else begin
                        sr_ser_inr = ser_rx_in;
                    end
                end else begin
                    tx_bit_valid = 1'b1;
                    ser_tx_out   = dir_q ? sr_ser_outl : sr_ser_outr;
                end
            end
            default: ;
        endcase
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE) && !abort;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;

endmodule

// File: tb/tb_uni_shft_ctrl.sv
// Self-checking bench for uni_shft_ctrl (WIDTH=4) with a behavioural shift register attached.
module tb_uni_shft_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         abort = 1'b0;
    logic [1:0]   sr_sel;
    logic [W-1:0] sr_par_in;
    logic         sr_ser_inr, sr_ser_inl;
    logic [W-1:0] sr_q = '0;
    logic         ser_rx_in = 1'b0;
    logic         rx_bit_ready, ser_tx_out, tx_bit_valid;
    logic [W-1:0] rx_data;
    logic         rx_valid, busy, done;

    int vectors = 0;
    int miscompares = 0;
    int accept_cnt = 0;

    uni_shft_ctrl_if #(.WIDTH(W)) cmd_if ();

    uni_shft_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .abort        (abort),
        .sr_sel       (sr_sel),
        .sr_par_in    (sr_par_in),
        .sr_ser_inr   (sr_ser_inr),
        .sr_ser_inl   (sr_ser_inl),
        .sr_par_out   (sr_q),
        .sr_ser_outr  (sr_q[0]),
        .sr_ser_outl  (sr_q[W-1]),
        .ser_rx_in    (ser_rx_in),
        .rx_bit_ready (rx_bit_ready),
        .ser_tx_out   (ser_tx_out),
        .tx_bit_valid (tx_bit_valid),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Universal shift register: right shift enters at MSB, left shift enters at LSB
    always @(posedge clk) begin
        case (sr_sel)
            2'd1:    sr_q <= {sr_ser_inr, sr_q[W-1:1]};
            2'd2:    sr_q <= {sr_q[W-2:0], sr_ser_inl};
            2'd3:    sr_q <= sr_par_in;
            default: sr_q <= sr_q;
        endcase
    end

    always @(posedge clk) begin
        if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) accept_cnt <= accept_cnt + 1;
    end

    typedef struct {
        logic         mode;
        logic         dir;
        logic [W-1:0] data;
        logic [W-1:0] rxb;    // rxb[i] is the i-th serial bit fed in
        logic [W-1:0] exp_s;  // exp_s[i] is the i-th serial bit expected out
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Order in which a TX word leaves the register
    function automatic logic [W-1:0] model_tx(input logic d, input logic [W-1:0] data);
        logic [W-1:0] s;
        for (int i = 0; i < W; i++) s[i] = d ? data[W-1-i] : data[i];
        return s;
    endfunction

    // Word assembled after W serial bits: right shifting pushes the first bit to LSB
    function automatic logic [W-1:0] model_rx(input logic d, input logic [W-1:0] s);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[d ? (W-1-i) : i] = s[i];
        return w;
    endfunction

    // Issue one command at a negedge in IDLE and check it cycle by cycle
    task automatic run_cmd(input logic m, input logic d, input logic [W-1:0] data,
                           input logic [W-1:0] rxb, input logic [W-1:0] exp_s,
                           input logic [W-1:0] exp_rx, input string tag);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_mode  = m;
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_data  = data;
        chk({tag, " ready_idle"}, cmd_if.cmd_ready, 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = W'($urandom);
        chk({tag, " load_sel"}, sr_sel, 3);
        chk({tag, " load_par"}, sr_par_in, m ? 0 : data);
        chk({tag, " load_ready"}, cmd_if.cmd_ready, 0);
        chk({tag, " load_busy"}, busy, 1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            ser_rx_in = rxb[i];
            #1;
            chk({tag, " shift_sel"}, sr_sel, d ? 2 : 1);
            chk({tag, " shift_done"}, done, 0);
            if (m) begin
                chk({tag, " rx_bit_ready"}, rx_bit_ready, 1);
                chk({tag, " tx_bit_valid"}, tx_bit_valid, 0);
                chk({tag, " ser_in_active"}, d ? sr_ser_inl : sr_ser_inr, rxb[i]);
                chk({tag, " ser_in_other"}, d ? sr_ser_inr : sr_ser_inl, 0);
            end else begin
                chk({tag, " tx_bit_valid"}, tx_bit_valid, 1);
                chk({tag, " ser_tx_out"}, ser_tx_out, exp_s[i]);
                chk({tag, " ser_in_zero"}, {sr_ser_inl, sr_ser_inr}, 0);
            end
        end
        @(negedge clk);
        ser_rx_in = 1'b0;
        chk({tag, " done_sel"}, sr_sel, 0);
        chk({tag, " done_pulse"}, done, 1);
        chk({tag, " done_ready"}, cmd_if.cmd_ready, 0);
        chk({tag, " done_txv"}, tx_bit_valid, 0);
        @(negedge clk);
        chk({tag, " idle_ready"}, cmd_if.cmd_ready, 1);
        chk({tag, " idle_done"}, done, 0);
        chk({tag, " rx_valid"}, rx_valid, m);
        if (m) chk({tag, " rx_data"}, rx_data, exp_rx);
        else   chk({tag, " tx_final_par"}, sr_q, 0);
        @(negedge clk);
        chk({tag, " rx_valid_clear"}, rx_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic         m, d;
        logic [W-1:0] data, rxb, s;

        tbl[0] = '{mode:1'b0, dir:1'b0, data:4'b1011, rxb:4'b0000, exp_s:4'b1011, exp_rx:4'b0000};
        tbl[1] = '{mode:1'b0, dir:1'b1, data:4'b1011, rxb:4'b0000, exp_s:4'b1101, exp_rx:4'b0000};
        tbl[2] = '{mode:1'b1, dir:1'b0, data:4'b0000, rxb:4'b1011, exp_s:4'b0000, exp_rx:4'b1011};
        tbl[3] = '{mode:1'b1, dir:1'b1, data:4'b1111, rxb:4'b0110, exp_s:4'b0000, exp_rx:4'b0110};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_mode  = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_data  = '0;

        // Reset state
        @(negedge clk);
        chk("rst sel", sr_sel, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", cmd_if.cmd_ready, 1);
        chk("rst rx_data", rx_data, 0);
        chk("rst rx_valid", rx_valid, 0);
        chk("rst done", done, 0);
        chk("rst outs", {sr_par_in, sr_ser_inl, sr_ser_inr, tx_bit_valid, rx_bit_ready, ser_tx_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++)
            run_cmd(tbl[v].mode, tbl[v].dir, tbl[v].data, tbl[v].rxb, tbl[v].exp_s, tbl[v].exp_rx, $sformatf("tbl%0d", v));

        // Abort in the second SHIFT cycle of a TX
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mode = 1'b0; cmd_if.cmd_dir = 1'b0; cmd_if.cmd_data = 4'b1001;
        @(negedge clk); cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort pre_sel", sr_sel, 1);
        abort = 1'b1;
        #1 chk("abort done_in", done, 0);
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort sel", sr_sel, 0);
        chk("abort done", done, 0);
        chk("abort ready", cmd_if.cmd_ready, 1);
        @(negedge clk);
        chk("abort no_done", done, 0);
        chk("abort no_rx_valid", rx_valid, 0);
        run_cmd(tbl[0].mode, tbl[0].dir, tbl[0].data, tbl[0].rxb, tbl[0].exp_s, tbl[0].exp_rx, "post_abort");

        // cmd_valid held high across the whole busy period gives one accept
        accept_cnt = 0;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mode = 1'b1; cmd_if.cmd_dir = 1'b0;
        for (int i = 0; i < W + 3; i++) @(negedge clk);
        chk("hold ready_back", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b0;
        chk("hold accepts", accept_cnt, 1);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of an RX
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_mode = 1'b1; cmd_if.cmd_dir = 1'b1;
        @(negedge clk); cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        ser_rx_in = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst sel", sr_sel, 0);
        chk("midrst busy", busy, 0);
        chk("midrst outs", {sr_ser_inl, sr_ser_inr, rx_bit_ready, tx_bit_valid, done, rx_valid}, 0);
        chk("midrst rx_data", rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        ser_rx_in = 1'b0;
        @(negedge clk);
        chk("midrst no_rx_valid", rx_valid, 0);

        // Randomized commands against the reference model
        for (int r = 0; r < 24; r++) begin
            m    = 1'($urandom_range(0, 1));
            d    = 1'($urandom_range(0, 1));
            data = W'($urandom);
            rxb  = W'($urandom);
            s    = model_tx(d, data);
            run_cmd(m, d, data, rxb, s, model_rx(d, rxb), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
